// File: rtl/tally_pkg.sv
// Shared definitions for the press_tally counter.
//   DIGIT_W        nibble width of each displayed digit
//   BCD_MAX_DIGIT  highest digit value in decimal mode
//   HEX_MAX_DIGIT  highest digit value in hex mode
//   count_dir_t    resolved step direction for one cycle
//   digit_step     one-digit increment/decrement with wrap and carry/borrow out
package tally_pkg;

    localparam int                 DIGIT_W       = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [DIGIT_W-1:0] HEX_MAX_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } count_dir_t;

    // Steps one digit in the range 0..max_d. Result is {wrap, next_digit};
    // wrap is the carry (up) or borrow (down) into the next digit.
    function automatic logic [DIGIT_W:0] digit_step(
        input logic [DIGIT_W-1:0] d,
        input logic               up,
        input logic [DIGIT_W-1:0] max_d
    );
        logic [DIGIT_W:0] r;
        if (up) begin
            r = (d == max_d) ? {1'b1, {DIGIT_W{1'b0}}} : {1'b0, DIGIT_W'(d + 1'b1)};
        end else begin
            r = (d == '0) ? {1'b1, max_d} : {1'b0, DIGIT_W'(d - 1'b1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/press_tally_btn_debounce.sv
// Per-button conditioning: 2-flop synchroniser, stability-counter debounce and
// rising-edge press detect.
//   clk, rst_n  system clock, asynchronous active-low reset
//   btn         raw, asynchronous, bouncy button level
//   level       accepted (debounced) level
//   press       one-cycle pulse on each accepted rising edge of level
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             db;
    logic             db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
            db_q <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            db_q <= db;
            // Any cycle that agrees with the accepted level restarts the
            // stability window, so only an unbroken run is ever accepted.
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = db;
    assign press = db & ~db_q;

endmodule

// File: rtl/press_tally.sv
// Two-digit up/down press counter driving a pair of nibble-to-segment decoders.
//   DEBOUNCE_CYCLES  stable cycles before a button level is accepted
//   DECIMAL          0: hex count 0x00..0xFF, 1: BCD count 00..99
//   clk, rst_n       system clock, asynchronous active-low reset
//   btn_up, btn_dn   raw active-high buttons
//   digit_hi/lo      upper/lower digit of the count (registered)
//   step             one-cycle pulse in the cycle the count changes
module press_tally
    import tally_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit DECIMAL         = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_dn,
    output logic [DIGIT_W-1:0] digit_hi,
    output logic [DIGIT_W-1:0] digit_lo,
    output logic               step
);

    localparam int                 NUM_BTN   = 2;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = DECIMAL ? BCD_MAX_DIGIT : HEX_MAX_DIGIT;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] unused_level;   // accepted levels, not needed here

    assign btn_raw = {btn_dn, btn_up};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_raw[g]),
            .level(unused_level[g]),
            .press(btn_press[g])
        );
    end

    // Simultaneous presses cancel; a press one cycle apart steps twice.
    count_dir_t dir;
    always_comb begin
        dir = DIR_NONE;
        if (btn_press == 2'b01) dir = DIR_UP;
        if (btn_press == 2'b10) dir = DIR_DN;
    end

    // Hex is the same digit chain with a 0xF digit limit, which reproduces
    // 8-bit modular arithmetic exactly.
    logic             dir_up;
    logic [DIGIT_W:0] lo_stepped;
    logic [DIGIT_W:0] hi_stepped;
    logic             unused_hi_wrap;

    assign dir_up         = (dir == DIR_UP);
    assign lo_stepped     = digit_step(digit_lo, dir_up, MAX_DIGIT);
    assign hi_stepped     = digit_step(digit_hi, dir_up, MAX_DIGIT);
    assign unused_hi_wrap = hi_stepped[DIGIT_W];   // overall wrap is silent

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_hi <= '0;
            digit_lo <= '0;
            step     <= 1'b0;
        end else begin
            step <= (dir != DIR_NONE);
            if (dir != DIR_NONE) begin
                digit_lo <= lo_stepped[DIGIT_W-1:0];
                if (lo_stepped[DIGIT_W]) digit_hi <= hi_stepped[DIGIT_W-1:0];
            end
        end
    end

endmodule

// File: doc/press_tally.md
# press_tally

Two-digit press counter feeding the board's pair of seven-segment decoders. Two raw push-buttons (up, down) are synchronised and debounced. Each clean press steps a two-digit count in hex or BCD, with wrap-around. `digit_hi`/`digit_lo` drive the 4-bit inputs of the tens and ones nibble-to-segment decoders directly.

## Interface
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles required before a button level is accepted (10 ms at 25 MHz); legal range 2..2^20.
- `DECIMAL`, 0, 0 = hex count 0x00..0xFF; 1 = BCD count 00..99.
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion assumed synchronous to `clk` by the board reset generator.
- `btn_up`  in  1  raw up button, active-high, asynchronous, bouncy.
- `btn_dn`  in  1  raw down button, active-high, asynchronous, bouncy.
- `digit_hi`  out  4  upper nibble of count (tens digit in BCD).
- `digit_lo`  out  4  lower nibble of count (ones digit in BCD).
- `step`  out  1  one-cycle pulse in the cycle the count register changes.

## Operation
- Per button: 2-flop synchroniser, then debounce.
  - The debouncer holds an accepted level `db` (reset 0) and a stability counter (reset 0).
  - If the synchronised level equals `db`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, `db` takes the new level and the counter clears.
  - Any return to `db` before that point clears the counter; glitches shorter than `DEBOUNCE_CYCLES` are never accepted.
- Press event: rising edge of `db`, one cycle wide. Release events are ignored.
- Count update, registered, in the cycle after the press event:
  - Up only: +1.
  - Down only: -1.
  - Both in the same cycle: no change, no `step`.
- Hex mode: 8-bit modular arithmetic. 0xFF+1 -> 0x00; 0x00-1 -> 0xFF.
- BCD mode, up: `digit_lo` 9 -> 0 with carry into `digit_hi`; 99+1 -> 00.
- BCD mode, down: `digit_lo` 0 -> 9 with borrow from `digit_hi`; 00-1 -> 99.
- BCD mode: nibble values 0xA..0xF never appear on either output.
- A held button counts once. Repeat requires release (accepted low) followed by a new accepted high.
- Reset: `digit_hi`=0, `digit_lo`=0, `step`=0, both `db`=0, counters and synchronisers 0.
  - Reset mid-press: the count returns to 00.
  - A button still held at reset release is accepted after `DEBOUNCE_CYCLES` and counts as one press.

## Timing
- `btn_up` first sampled high at edge k and held: synchroniser output high after edge k+1.
- `db` rises at edge k+1+`DEBOUNCE_CYCLES`.
- Press event is combinational from the `db` edge. The count and `step` update at edge k+2+`DEBOUNCE_CYCLES`.
- End-to-end latency is therefore `DEBOUNCE_CYCLES`+2 clocks after first sample.
- `step` is high for exactly one cycle per count change.
- Outputs are registered, with no combinational path from inputs to outputs.
- Minimum press-to-press spacing: 2×`DEBOUNCE_CYCLES` (accept high plus accept low).

## Structure
- Package `tally_pkg` holds:
  - `DIGIT_W` = 4.
  - `BCD_MAX_DIGIT` = 4'd9.
  - `HEX_MAX_DIGIT` = 4'hF.
  - Enum `count_dir_t` {`DIR_NONE`, `DIR_UP`, `DIR_DN`} for the resolved step direction.
- Sub-module `btn_debounce`, parameterised by `DEBOUNCE_CYCLES`:
  - Contains the synchroniser, stability counter and `db` register.
  - Outputs `level` and a one-cycle `press` pulse.
  - Instantiated twice.
- `press_tally` holds direction resolution, the digit arithmetic and the output registers.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`.

## Test plan
Bench runs with `DEBOUNCE_CYCLES`=4.
- Clean up press held 20 cycles after reset, hex mode -> `digit_hi`/`digit_lo` 0/0 -> 0/1 exactly 6 clocks after first sample; one `step` pulse; no further change while held.
- Up toggling every 2 cycles for 30 cycles, then held high -> exactly one increment, occurring 4 stable cycles after the final rise is synchronised.
- Wrap, hex: preload via 255 up presses to 0xFF, then one up press -> 0x00; then one down press -> 0xFF.
- Wrap, BCD (`DECIMAL`=1): 09+1 -> 10; 99+1 -> 00; 00-1 -> 99; 10-1 -> 09; outputs never exceed 9.
- Up and down accepted in the same cycle -> count unchanged and `step` stays 0; up accepted one cycle later than down -> net 0 with two `step` pulses.
- Assert `rst_n` low mid-debounce at count 0x37 -> outputs 0/0 immediately (asynchronous); with the button still held at release -> count 0x01 `DEBOUNCE_CYCLES`+2 cycles later.
